// File: rtl/kalman_pkg.sv
// Shared Q16.16 constants and controller state encoding for the Kalman sampling front-end.
package kalman_pkg;

  localparam int          Q_W    = 32;
  localparam int          Q_FRAC = 16;
  localparam logic [31:0] Q_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ADC = 3'd2,
    ST_SCALE    = 3'd3,
    ST_FIRE     = 3'd4,
    ST_WAIT_KF  = 3'd5
  } state_t;

endpackage

// File: rtl/kalman_sample_ctrl_if.sv
// ADC-side and filter-side signal bundle; master is the sampling controller.
interface kalman_sample_ctrl_if
  import kalman_pkg::*;
#(
  parameter int ADC_W = 12
);

  logic             o_adc_start;
  logic             i_adc_done;
  logic [ADC_W-1:0] i_adc_u;
  logic [ADC_W-1:0] i_adc_y;
  logic [Q_W-1:0]   o_u;
  logic [Q_W-1:0]   o_y;
  logic             o_begin;
  logic             i_kf_dv;
  logic             o_busy;
  logic             o_overrun;
  logic             o_adc_err;

  modport master (
    output o_adc_start, o_u, o_y, o_begin, o_busy, o_overrun, o_adc_err,
    input  i_adc_done, i_adc_u, i_adc_y, i_kf_dv
  );

  modport slave (
    input  o_adc_start, o_u, o_y, o_begin, o_busy, o_overrun, o_adc_err,
    output i_adc_done, i_adc_u, i_adc_y, i_kf_dv
  );

endinterface

// File: rtl/kalman_sample_ctrl_adc_scale_sat.sv
// Combinational averaged-code times gain, saturated to the largest positive Q16.16 value.
module adc_scale_sat
  import kalman_pkg::*;
#(
  parameter int          ADC_W = 12,
  parameter logic [31:0] GAIN  = 32'h0000_1000
) (
  input  logic [ADC_W-1:0] avg,
  output logic [Q_W-1:0]   q
);

  logic [ADC_W+Q_W-1:0] prod;

  always_comb begin
    prod = {{Q_W{1'b0}}, avg} * {{ADC_W{1'b0}}, GAIN};
    if (prod > {{ADC_W{1'b0}}, Q_MAX}) begin
      q = Q_MAX;
    end else begin
      q = prod[Q_W-1:0];
    end
  end

endmodule

// File: rtl/kalman_sample_ctrl.sv
// Paces the Kalman filter: per period runs 2^OSR_LOG2 conversions, averages/scales them
// to Q16.16, pulses o_begin and holds o_u/o_y until the filter reports i_kf_dv.
module kalman_sample_ctrl
  import kalman_pkg::*;
#(
  parameter int          ADC_W       = 12,
  parameter int          OSR_LOG2    = 2,
  parameter int          SAMPLE_DIV  = 1000,
  parameter int          ADC_TIMEOUT = 255,
  parameter logic [31:0] U_GAIN      = 32'h0000_1000,
  parameter logic [31:0] Y_GAIN      = 32'h0000_1000
) (
  input logic                  i_clk,
  input logic                  i_rst,
  kalman_sample_ctrl_if.master bus
);

  localparam int ACC_W = ADC_W + OSR_LOG2;
  localparam int CNT_W = OSR_LOG2 + 1;
  localparam int PER_W = $clog2(SAMPLE_DIV);
  localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CONV = CNT_W'((1 << OSR_LOG2) - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ADC_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PER_W-1:0] per_cnt;
  logic             tick;
  logic [ACC_W-1:0] acc_u;
  logic [ACC_W-1:0] acc_y;
  logic [ACC_W-1:0] acc_u_nxt;
  logic [ACC_W-1:0] acc_y_nxt;
  logic [ADC_W-1:0] avg_u;
  logic [ADC_W-1:0] avg_y;
  logic [Q_W-1:0]   scaled_u;
  logic [Q_W-1:0]   scaled_y;
  logic [CNT_W-1:0] conv_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             last_conv;
  logic             tmo_hit;
  logic [Q_W-1:0]   u_q;
  logic [Q_W-1:0]   y_q;
  logic             overrun_q;
  logic             err_q;
  logic             adc_start;
  logic             kf_begin;
  logic             busy;

  assign tick      = (per_cnt == PER_LAST);
  assign last_conv = (conv_cnt == LAST_CONV);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign acc_u_nxt = acc_u + ACC_W'(bus.i_adc_u);
  assign acc_y_nxt = acc_y + ACC_W'(bus.i_adc_y);

  // Scaling works on the sum including the conversion landing this cycle, so the
  // result is registered on the final i_adc_done and is already valid during SCALE.
  assign avg_u = acc_u_nxt[ACC_W-1:OSR_LOG2];
  assign avg_y = acc_y_nxt[ACC_W-1:OSR_LOG2];

  adc_scale_sat #(.ADC_W(ADC_W), .GAIN(U_GAIN)) u_scale_u (.avg(avg_u), .q(scaled_u));
  adc_scale_sat #(.ADC_W(ADC_W), .GAIN(Y_GAIN)) u_scale_y (.avg(avg_y), .q(scaled_y));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    kf_begin  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (tick) state_nxt = ST_START;
      end
      ST_START: begin
        adc_start = 1'b1;
        state_nxt = ST_WAIT_ADC;
      end
      ST_WAIT_ADC: begin
        if (bus.i_adc_done) begin
          state_nxt = last_conv ? ST_SCALE : ST_START;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SCALE: state_nxt = ST_FIRE;
      ST_FIRE: begin
        kf_begin  = 1'b1;
        state_nxt = ST_WAIT_KF;
      end
      ST_WAIT_KF: begin
        if (bus.i_kf_dv) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_cnt   <= '0;
      acc_u     <= '0;
      acc_y     <= '0;
      conv_cnt  <= '0;
      tmo_cnt   <= '0;
      u_q       <= '0;
      y_q       <= '0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      per_cnt <= tick ? '0 : per_cnt + 1'b1;
      // A period arriving while any transaction is in flight is dropped, not queued.
      if (tick && (state != ST_IDLE)) overrun_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          acc_u    <= '0;
          acc_y    <= '0;
          conv_cnt <= '0;
        end
        ST_START: tmo_cnt <= '0;
        ST_WAIT_ADC: begin
          if (bus.i_adc_done) begin
            acc_u    <= acc_u_nxt;
            acc_y    <= acc_y_nxt;
            conv_cnt <= conv_cnt + 1'b1;
            if (last_conv) begin
              u_q <= scaled_u;
              y_q <= scaled_y;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_adc_start = adc_start;
  assign bus.o_begin     = kf_begin;
  assign bus.o_busy      = busy;
  assign bus.o_u         = u_q;
  assign bus.o_y         = y_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_adc_err   = err_q;

endmodule

// File: tb/tb_kalman_sample_ctrl.sv
// Bench for kalman_sample_ctrl: table vectors, multi-cycle corner sequences and random periods
// against a reference model; a second instance with a saturating u gain shares the stimulus.
module tb_kalman_sample_ctrl;
  import kalman_pkg::*;

  localparam int          ADC_W       = 12;
  localparam int          OSR_LOG2    = 2;
  localparam int          NCONV       = 4;
  localparam int          SAMPLE_DIV  = 400;
  localparam int          ADC_TIMEOUT = 100;
  localparam logic [31:0] GAIN        = 32'h0000_1000;
  localparam logic [31:0] SAT_GAIN    = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [NCONV-1:0][ADC_W-1:0] u;
    logic [NCONV-1:0][ADC_W-1:0] y;
    logic [31:0]                 exp_u;
    logic [31:0]                 exp_y;
    logic [31:0]                 exp_us;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_begin = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.o_adc_start) n_start <= n_start + 1;
    if (bus.o_begin)     n_begin <= n_begin + 1;
  end

  kalman_sample_ctrl_if #(.ADC_W(ADC_W)) bus ();
  kalman_sample_ctrl_if #(.ADC_W(ADC_W)) bus_s ();

  assign bus_s.i_adc_done = bus.i_adc_done;
  assign bus_s.i_adc_u    = bus.i_adc_u;
  assign bus_s.i_adc_y    = bus.i_adc_y;
  assign bus_s.i_kf_dv    = bus.i_kf_dv;

  kalman_sample_ctrl #(
    .ADC_W(ADC_W), .OSR_LOG2(OSR_LOG2), .SAMPLE_DIV(SAMPLE_DIV),
    .ADC_TIMEOUT(ADC_TIMEOUT), .U_GAIN(GAIN), .Y_GAIN(GAIN)
  ) dut (.i_clk(clk), .i_rst(rst), .bus(bus.master));

  kalman_sample_ctrl #(
    .ADC_W(ADC_W), .OSR_LOG2(OSR_LOG2), .SAMPLE_DIV(SAMPLE_DIV),
    .ADC_TIMEOUT(ADC_TIMEOUT), .U_GAIN(SAT_GAIN), .Y_GAIN(GAIN)
  ) dut_s (.i_clk(clk), .i_rst(rst), .bus(bus_s.master));

  function automatic logic [31:0] ref_scale(input logic [NCONV-1:0][ADC_W-1:0] c,
                                            input logic [31:0] gain);
    longint unsigned sum = 0;
    longint unsigned prod;
    for (int i = 0; i < NCONV; i++) sum += longint'(c[i]);
    prod = (sum / NCONV) * longint'(gain);
    return (prod > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : 32'(prod);
  endfunction

  function automatic vec_t mk(input int u0, u1, u2, u3, y0, y1, y2, y3,
                              input logic [31:0] eu, ey, eus);
    vec_t v;
    v.u[0] = 12'(u0); v.u[1] = 12'(u1); v.u[2] = 12'(u2); v.u[3] = 12'(u3);
    v.y[0] = 12'(y0); v.y[1] = 12'(y1); v.y[2] = 12'(y2); v.y[3] = 12'(y3);
    v.exp_u = eu; v.exp_y = ey; v.exp_us = eus;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
  endtask

  task automatic wait_start(output int s_cyc);
    int k = 0;
    while (!bus.o_adc_start && k < SAMPLE_DIV + 20) begin
      step();
      k++;
    end
    check("start_seen", 32'(bus.o_adc_start), 32'd1);
    s_cyc = cyc;
  endtask

  // Runs one full conversion burst and checks results up to the o_begin pulse.
  task automatic do_conv(input vec_t v, input bit rnd, output int s_cyc);
    int dly;
    for (int i = 0; i < NCONV; i++) begin
      if (i == 0) wait_start(s_cyc);
      else check("restart", 32'(bus.o_adc_start), 32'd1);
      dly = rnd ? int'($urandom_range(1, 12)) : 5;
      repeat (dly) step();
      bus.i_adc_done = 1'b1;
      bus.i_adc_u    = v.u[i];
      bus.i_adc_y    = v.y[i];
      step();
      bus.i_adc_done = 1'b0;
      bus.i_adc_u    = 12'($urandom);
      bus.i_adc_y    = 12'($urandom);
    end
    check("o_u", bus.o_u, v.exp_u);
    check("o_y", bus.o_y, v.exp_y);
    check("sat_o_u", bus_s.o_u, v.exp_us);
    check("sat_o_y", bus_s.o_y, v.exp_y);
    check("begin_early", 32'(bus.o_begin), 32'd0);
    step();
    check("begin", 32'(bus.o_begin), 32'd1);
    step();
    check("begin_one_cycle", 32'(bus.o_begin), 32'd0);
  endtask

  task automatic finish_kf(input vec_t v, input int dly);
    repeat (dly) step();
    check("hold_u", bus.o_u, v.exp_u);
    check("busy_wait_kf", 32'(bus.o_busy), 32'd1);
    bus.i_kf_dv = 1'b1;
    step();
    bus.i_kf_dv = 1'b0;
    check("idle_after_dv", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_u"}, bus.o_u, 32'd0);
    check({tag, "_y"}, bus.o_y, 32'd0);
    check({tag, "_sat_u"}, bus_s.o_u, 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_start"}, 32'(bus.o_adc_start), 32'd0);
    check({tag, "_begin"}, 32'(bus.o_begin), 32'd0);
    check({tag, "_overrun"}, 32'(bus.o_overrun), 32'd0);
    check({tag, "_err"}, 32'(bus.o_adc_err), 32'd0);
  endtask

  initial begin
    int   s, s2, nb, ns;
    vec_t v;
    vecs[0] = mk(560, 560, 560, 560, 1280, 1280, 1280, 1280,
                 32'h0023_0000, 32'h0050_0000, 32'h7FFF_FFFF);
    vecs[1] = mk(100, 101, 102, 104, 0, 0, 0, 3,
                 32'h0006_5000, 32'h0000_0000, 32'h7FFF_FFFF);
    vecs[2] = mk(4095, 4095, 4095, 4095, 4095, 4095, 4095, 4094,
                 32'h00FF_F000, 32'h00FF_E000, 32'h7FFF_FFFF);
    vecs[3] = mk(0, 0, 0, 0, 1, 2, 3, 1,
                 32'h0000_0000, 32'h0000_1000, 32'h0000_0000);
    bus.i_adc_done = 1'b0;
    bus.i_adc_u    = '0;
    bus.i_adc_y    = '0;
    bus.i_kf_dv    = 1'b0;

    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_conv(vecs[i], 1'b0, s);
      finish_kf(vecs[i], 3);
    end
    check("no_overrun", 32'(bus.o_overrun), 32'd0);

    // ADC never answers
    wait_start(s);
    nb = n_begin;
    repeat (ADC_TIMEOUT - 1) step();
    check("err_not_yet", 32'(bus.o_adc_err), 32'd0);
    repeat (2) step();
    check("adc_err", 32'(bus.o_adc_err), 32'd1);
    check("tmo_idle", 32'(bus.o_busy), 32'd0);
    check("tmo_u_kept", bus.o_u, vecs[3].exp_u);
    check("tmo_y_kept", bus.o_y, vecs[3].exp_y);
    check("tmo_no_begin", 32'(n_begin), 32'(nb));
    check("tmo_no_overrun", 32'(bus.o_overrun), 32'd0);

    // i_kf_dv lands on the same cycle as the next tick
    do_conv(vecs[0], 1'b0, s);
    while (cyc < s + SAMPLE_DIV - 1) step();
    bus.i_kf_dv = 1'b1;
    step();
    bus.i_kf_dv = 1'b0;
    check("coinc_overrun", 32'(bus.o_overrun), 32'd1);
    check("coinc_idle", 32'(bus.o_busy), 32'd0);
    ns = n_start;
    repeat (SAMPLE_DIV - 10) step();
    check("coinc_tick_dropped", 32'(n_start), 32'(ns));
    do_conv(vecs[1], 1'b0, s2);
    check("coinc_next_period", 32'(s2 - s), 32'(2 * SAMPLE_DIV));
    finish_kf(vecs[1], 2);

    // Reset in the middle of WAIT_ADC
    wait_start(s);
    repeat (2) step();
    nb = n_begin;
    rst = 1'b1;
    #1;
    check_zero("rst_adc");
    repeat (2) step();
    rst = 1'b0;
    do_conv(vecs[2], 1'b0, s);
    check("rst_adc_begins", 32'(n_begin), 32'(nb + 1));
    finish_kf(vecs[2], 2);

    // Reset while waiting on the filter
    do_conv(vecs[3], 1'b0, s);
    nb = n_begin;
    rst = 1'b1;
    #1;
    check_zero("rst_kf");
    repeat (2) step();
    rst = 1'b0;
    do_conv(vecs[0], 1'b0, s);
    check("rst_kf_begins", 32'(n_begin), 32'(nb + 1));
    finish_kf(vecs[0], 2);

    // Filter holds off past a whole period
    do_conv(vecs[1], 1'b0, s);
    ns = n_start;
    repeat (SAMPLE_DIV + 5) step();
    check("hold_overrun", 32'(bus.o_overrun), 32'd1);
    check("hold_no_start", 32'(n_start), 32'(ns));
    check("hold_busy", 32'(bus.o_busy), 32'd1);
    finish_kf(vecs[1], 0);
    do_conv(vecs[2], 1'b0, s);
    check("overrun_sticky", 32'(bus.o_overrun), 32'd1);
    finish_kf(vecs[2], 2);

    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < NCONV; i++) begin
        v.u[i] = 12'($urandom);
        v.y[i] = 12'($urandom);
      end
      v.exp_u  = ref_scale(v.u, GAIN);
      v.exp_y  = ref_scale(v.y, GAIN);
      v.exp_us = ref_scale(v.u, SAT_GAIN);
      do_conv(v, 1'b1, s);
      finish_kf(v, int'($urandom_range(0, 30)));
    end
    check("final_err_clear", 32'(bus.o_adc_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kalman_sample_ctrl.md
Name: kalman_sample_ctrl

Overview:
Upstream front-end for the boost-converter Kalman filter. Paces the filter at a fixed sampling period and, each period, runs 2^OSR_LOG2 ADC conversions of the PV voltage (u) and output voltage (y). It averages and scales the raw codes to signed Q16.16 volts, presents them stable on o_u/o_y, fires a one-cycle o_begin, and holds the values until the filter returns its data-valid.

Parameters:
ADC_W, 12, raw ADC code width (unsigned codes)
OSR_LOG2, 2, log2 of conversions averaged per period (0..4)
SAMPLE_DIV, 1000, clocks per sampling period (>= 64)
ADC_TIMEOUT, 255, max clocks to wait for i_adc_done per conversion
U_GAIN, 32'h0000_1000, unsigned Q16.16 volts per LSB for u channel
Y_GAIN, 32'h0000_1000, unsigned Q16.16 volts per LSB for y channel

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
o_adc_start  out  1  one-cycle conversion request to ADC interface
i_adc_done  in  1  one-cycle pulse: i_adc_u/i_adc_y valid this cycle
i_adc_u  in  ADC_W  raw u code
i_adc_y  in  ADC_W  raw y code
o_u  out  32  signed Q16.16 averaged u, to filter i_u
o_y  out  32  signed Q16.16 averaged y, to filter i_y
o_begin  out  1  one-cycle start pulse, to filter i_begin
i_kf_dv  in  1  filter o_DV (end of update)
o_busy  out  1  high in any state other than IDLE
o_overrun  out  1  sticky: period tick arrived while not IDLE
o_adc_err  out  1  sticky: conversion timed out

Behaviour:
- Reset (async, any state): FSM=IDLE. Period counter, accumulators, conversion count and timeout counter are 0. All outputs are 0, including sticky flags.
- Period counter: free-running 0..SAMPLE_DIV-1. tick = (count==SAMPLE_DIV-1). Never stalls and is never re-phased.
- FSM states: IDLE, START, WAIT_ADC, SCALE, FIRE, WAIT_KF.
- IDLE: on tick -> START. Clear accumulators and conversion count.
- START: o_adc_start=1 for exactly this cycle. Clear timeout counter. -> WAIT_ADC.
- WAIT_ADC, on i_adc_done: acc_u+=i_adc_u, acc_y+=i_adc_y, cnt++. If cnt reaches 2^OSR_LOG2 -> SCALE, else -> START.
- WAIT_ADC, no done: timeout counter increments. At ADC_TIMEOUT, set o_adc_err and -> IDLE. o_u/o_y keep their old values and there is no o_begin.
- Accumulators are ADC_W+OSR_LOG2 bits unsigned. avg = acc >> OSR_LOG2 (truncate).
- SCALE: product = avg * GAIN (unsigned, ADC_W+32 bits). If product > 0x7FFF_FFFF, saturate to 0x7FFF_FFFF, else take the low 32 bits. Register to o_u/o_y. -> FIRE.
- FIRE: o_begin=1 for one cycle. -> WAIT_KF.
- WAIT_KF: on i_kf_dv -> IDLE.
- o_u/o_y change only in SCALE. They are stable from o_begin until i_kf_dv, which the filter requires because it samples them several cycles after begin.
- Latency: tick -> o_adc_start next cycle. Last i_adc_done -> o_u/o_y valid 1 cycle later. o_begin follows 1 cycle after that.
- A tick while FSM != IDLE sets o_overrun. That period is dropped (no queueing); the next tick is serviced normally.
- i_adc_done outside WAIT_ADC is ignored. i_kf_dv outside WAIT_KF is ignored.
- Tick and i_kf_dv in the same cycle while in WAIT_KF: overrun is set, FSM -> IDLE, and that tick is not serviced.
- Reset mid-conversion or mid-WAIT_KF: immediate return to IDLE with zeroed outputs. No o_begin is produced.

Decomposition:
- Shared package kalman_pkg: Q16.16 width/fraction constants (32, 16), Q_ONE=32'h0001_0000, Q_MAX=32'h7FFF_FFFF, FSM state encoding.
- One sub-module: adc_scale_sat, combinational avg*gain with saturation. Instantiated twice (u, y).

Test Plan:
- OSR_LOG2=2, gains 0x1000; ADC returns u=560, y=1280 each conversion (done 5 clocks after start) -> after 4 conversions o_u=0x0023_0000 (35.0 V), o_y=0x0050_0000 (80.0 V), then one o_begin pulse, o_busy high until i_kf_dv.
- u codes 100,101,102,104 -> avg 101 (407>>2, truncation) -> o_u=0x0006_5000.
- U_GAIN=0x7FFF_FFFF, u=4095 -> o_u saturates to 0x7FFF_FFFF; y path unaffected.
- Hold i_kf_dv low past one period -> o_overrun=1 at that tick, no new o_adc_start; release i_kf_dv -> next tick services normally with o_overrun still 1.
- Never assert i_adc_done -> o_adc_err=1 after ADC_TIMEOUT cycles, no o_begin, o_u/o_y unchanged, FSM IDLE.
- Assert i_rst during WAIT_ADC and again during WAIT_KF -> all outputs 0 the same cycle, no o_begin after release; first tick after release restarts cleanly.
